// File: rtl/dpram_arb.sv
// True dual-port RAM with registered reads, same-address write arbitration and a post-reset init sweep.
// Optional per-word even parity with read-side error flags when DPRAM_PARITY_EN is defined.
module dpram_arb #(
  parameter int unsigned          DW            = 8,
  parameter int unsigned          AW            = 4,
  parameter int unsigned          CONFLICT_MODE = 0,
  parameter logic [DW-1:0]        INIT_VALUE    = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_a,
  input  logic          wr_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic [DW-1:0] rdata_a,
  output logic          rvalid_a,
  input  logic          en_b,
  input  logic          wr_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic [DW-1:0] rdata_b,
  output logic          rvalid_b,
  output logic          conflict,
  output logic          init_busy
`ifdef DPRAM_PARITY_EN
  ,
  output logic          perr_a,
  output logic          perr_b
`endif
);

  localparam int unsigned DEPTH = 1 << AW;
`ifdef DPRAM_PARITY_EN
  localparam int unsigned MW = DW + 1;
`else
  localparam int unsigned MW = DW;
`endif

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_init_cnt;
  logic [AW-1:0]   w_init_cnt_nxt;

  logic [MW-1:0]   r_mem [DEPTH];
  logic [DW-1:0]   r_rdata_a;
  logic [DW-1:0]   r_rdata_b;
  logic            r_rvalid_a;
  logic            r_rvalid_b;

  logic            w_busy;
  logic            w_write_a;
  logic            w_write_b;
  logic            w_read_a;
  logic            w_read_b;
  logic            w_conflict;
  logic            w_we_a;
  logic            w_we_b;
  logic            w_sweep_we;
  logic [MW-1:0]   w_word_a;
  logic [MW-1:0]   w_word_b;
  logic [MW-1:0]   w_word_init;
  logic [MW-1:0]   w_rword_a;
  logic [MW-1:0]   w_rword_b;

  function automatic logic [MW-1:0] make_word(input logic [DW-1:0] d);
`ifdef DPRAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Port decode and arbitration
  // ---------------------------------------------------------------------------
  assign w_busy     = (r_state == ST_INIT);
  assign w_write_a  = en_a &  wr_a & ~w_busy;
  assign w_write_b  = en_b &  wr_b & ~w_busy;
  assign w_read_a   = en_a & ~wr_a & ~w_busy;
  assign w_read_b   = en_b & ~wr_b & ~w_busy;
  assign w_conflict = w_write_a & w_write_b & (addr_a == addr_b);

  // On a same-address collision only the winning port (if any) keeps its write.
  assign w_we_a = w_write_a & ~(w_conflict & (CONFLICT_MODE != 1));
  assign w_we_b = w_write_b & ~(w_conflict & (CONFLICT_MODE != 2));

  assign w_sweep_we  = w_busy & ~rst;
  assign w_word_a    = make_word(wdata_a);
  assign w_word_b    = make_word(wdata_b);
  assign w_word_init = make_word(INIT_VALUE);

  assign conflict  = w_conflict;
  assign init_busy = w_busy;

  // ---------------------------------------------------------------------------
  // Init sweep FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    case (r_state)
      ST_INIT: begin
        w_init_cnt_nxt = r_init_cnt + 1'b1;
        if (r_init_cnt == {AW{1'b1}}) begin
          w_state_nxt    = ST_RUN;
          w_init_cnt_nxt = '0;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; it is cleared by the init sweep so it
  // can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_mem[r_init_cnt] <= w_word_init;
    end else begin
      if (w_we_a) r_mem[addr_a] <= w_word_a;
      if (w_we_b) r_mem[addr_b] <= w_word_b;
    end
  end

  // Reads sample the array before this edge's writes land, giving read-first behaviour.
  assign w_rword_a = r_mem[addr_a];
  assign w_rword_b = r_mem[addr_b];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rvalid_a <= w_read_a;
      r_rvalid_b <= w_read_b;
      if (w_read_a) r_rdata_a <= w_rword_a[DW-1:0];
      if (w_read_b) r_rdata_b <= w_rword_b[DW-1:0];
    end
  end

  assign rdata_a  = r_rdata_a;
  assign rdata_b  = r_rdata_b;
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;

`ifdef DPRAM_PARITY_EN
  logic r_perr_a;
  logic r_perr_b;

  // Flags are only meaningful alongside rvalid; they are reported, never corrected.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perr_a <= 1'b0;
      r_perr_b <= 1'b0;
    end else begin
      r_perr_a <= w_read_a & (w_rword_a[DW] ^ (^w_rword_a[DW-1:0]));
      r_perr_b <= w_read_b & (w_rword_b[DW] ^ (^w_rword_b[DW-1:0]));
    end
  end

  assign perr_a = r_perr_a;
  assign perr_b = r_perr_b;
`endif

endmodule

// File: tb/tb_dpram_arb.sv
// Directed bench for dpram_arb: reference memory model feeds a per-port scoreboard of expected reads.
// Parity checks are built only when DPRAM_PARITY_EN is defined.
module tb_dpram_arb;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 4;
  localparam int unsigned CM  = 0;
  localparam logic [7:0]  IV  = 8'hA5;

  typedef struct {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_a, wr_a, en_b, wr_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b;
  logic          conflict, init_busy;
`ifdef DPRAM_PARITY_EN
  logic          perr_a, perr_b;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [7:0]  m_mem [16];
  logic        m_bad [16];
  bit          m_busy = 1'b1;
  logic [7:0]  last_a = 8'h00;
  logic [7:0]  last_b = 8'h00;

  dpram_arb #(
    .DW(DW), .AW(AW), .CONFLICT_MODE(CM), .INIT_VALUE(IV)
  ) dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .en_b(en_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .conflict(conflict), .init_busy(init_busy)
`ifdef DPRAM_PARITY_EN
    , .perr_a(perr_a), .perr_b(perr_b)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200us");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_model();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = IV;
      m_bad[i] = 1'b0;
    end
  endtask

  // One clock; outputs are sampled on the falling edge and matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    check("rvalid_a", {31'd0, rvalid_a}, {31'd0, q_a.size() != 0});
    if (q_a.size() != 0) begin
      e = q_a.pop_front();
      check("rdata_a", {24'd0, rdata_a}, {24'd0, e.data});
`ifdef DPRAM_PARITY_EN
      check("perr_a", {31'd0, perr_a}, {31'd0, e.perr});
`endif
      last_a = e.data;
    end else begin
      check("hold_a", {24'd0, rdata_a}, {24'd0, last_a});
    end
    check("rvalid_b", {31'd0, rvalid_b}, {31'd0, q_b.size() != 0});
    if (q_b.size() != 0) begin
      e = q_b.pop_front();
      check("rdata_b", {24'd0, rdata_b}, {24'd0, e.data});
`ifdef DPRAM_PARITY_EN
      check("perr_b", {31'd0, perr_b}, {31'd0, e.perr});
`endif
      last_b = e.data;
    end else begin
      check("hold_b", {24'd0, rdata_b}, {24'd0, last_b});
    end
  endtask

  task automatic drive(input logic ea, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                       input logic eb, input logic wb, input logic [3:0] ab, input logic [7:0] db);
    exp_t e;
    logic wra, wrb;
    en_a = ea; wr_a = wa; addr_a = aa; wdata_a = da;
    en_b = eb; wr_b = wb; addr_b = ab; wdata_b = db;
    wra = ea && wa;
    wrb = eb && wb;
    #1;
    check("conflict", {31'd0, conflict}, {31'd0, !m_busy && wra && wrb && (aa == ab)});
    if (!m_busy) begin
      if (ea && !wa) begin e.data = m_mem[aa]; e.perr = m_bad[aa]; q_a.push_back(e); end
      if (eb && !wb) begin e.data = m_mem[ab]; e.perr = m_bad[ab]; q_b.push_back(e); end
      if (wra && wrb && (aa == ab)) begin
        if (CM == 1) begin m_mem[aa] = da; m_bad[aa] = 1'b0; end
        if (CM == 2) begin m_mem[ab] = db; m_bad[ab] = 1'b0; end
      end else begin
        if (wra) begin m_mem[aa] = da; m_bad[aa] = 1'b0; end
        if (wrb) begin m_mem[ab] = db; m_bad[ab] = 1'b0; end
      end
    end
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic set_idle();
    en_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
    en_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rdata_a"},  {24'd0, rdata_a},   32'd0);
    check({tag, "_rdata_b"},  {24'd0, rdata_b},   32'd0);
    check({tag, "_rvalid_a"}, {31'd0, rvalid_a},  32'd0);
    check({tag, "_rvalid_b"}, {31'd0, rvalid_b},  32'd0);
    check({tag, "_busy"},     {31'd0, init_busy}, 32'd1);
`ifdef DPRAM_PARITY_EN
    check({tag, "_perr_a"},   {31'd0, perr_a},    32'd0);
`endif
    last_a = 8'h00;
    last_b = 8'h00;
  endtask

  initial begin
    int cnt;
    set_idle();
    rst = 1'b1;

    // Reset and full init sweep
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    check("rst_conflict", {31'd0, conflict}, 32'd0);
    rst = 1'b0;
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 40) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    check("init_len", cnt, 32'd16);
    fill_model();
    m_busy = 1'b0;

    // Back-to-back sweep of every address on both ports
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 1'b0, 4'(15 - i), 8'h00);
    end
    idle();

    // Simultaneous writes to different addresses, then cross reads
    drive(1'b1, 1'b1, 4'd2, 8'h3C, 1'b1, 1'b1, 4'd9, 8'hC3);
    drive(1'b1, 1'b0, 4'd9, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00);
    idle();

    // Same-address write conflict
    drive(1'b1, 1'b1, 4'd5, 8'h11, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1'b1, 1'b1, 4'd5, 8'h22, 1'b1, 1'b1, 4'd5, 8'h33);
    drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00);
    idle();

    // Read-first across ports
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd7, 8'h01);
    drive(1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b1, 4'd7, 8'hFF);
    drive(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    idle();

    // Reset in RUN, then reset again partway through the sweep
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_run");
    rst = 1'b0;
    m_busy = 1'b1;
    fill_model();
    repeat (6) idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", {31'd0, init_busy}, 32'd1);
    rst = 1'b0;
    drive(1'b1, 1'b1, 4'd0, 8'h5A, 1'b1, 1'b1, 4'd0, 8'h77);
    drive(1'b1, 1'b1, 4'd0, 8'h5A, 1'b1, 1'b0, 4'd1, 8'h00);
    set_idle();
    cnt = 2;
    while (init_busy === 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("restart_len", cnt, 32'd16);
    m_busy = 1'b0;
    drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd6, 8'h00);
    idle();

`ifdef DPRAM_PARITY_EN
    // Stored parity flip must be reported with the read, not corrected
    drive(1'b1, 1'b1, 4'd3, 8'h07, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    idle();
    dut.r_mem[3][DW] = ~dut.r_mem[3][DW];
    m_bad[3] = 1'b1;
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00);
    idle();
`endif

    check("scoreboard_empty", q_a.size() + q_b.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
